// File: rtl/gshare_pht.sv
// rtl/gshare_pht.sv - gshare branch predictor front-end: global history register plus 2-bit counter PHT (optional macro GSHARE_PHT_BYPASS_EN)
module gshare_pht #(
    parameter int GHR_W  = 8,
    parameter int PC_LSB = 2,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc_if,
    output logic              pred_bit_if,
    output logic [GHR_W-1:0]  pattern_if,
    input  logic              en_ex,
    input  logic [PC_W-1:0]   pc_ex,
    input  logic [GHR_W-1:0]  pattern_old_ex,
    input  logic              pred_bit_ex,
    input  logic              miss_ex,
    input  logic [GHR_W-1:0]  pattern_new_ex,
    output logic [GHR_W-1:0]  ghr_o
);

    localparam int PHT_N = 1 << GHR_W;

    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [1:0]       pht_q [PHT_N];
    logic [1:0]       pht_d [PHT_N];

    logic [GHR_W-1:0] idx_if;
    logic [GHR_W-1:0] idx_ex;
    logic             taken_ex;
    logic [1:0]       cnt_ex;
    logic [1:0]       cnt_new;
    logic             unused_pc_bits;

    // PC bits outside the hashed window do not take part in indexing
    assign unused_pc_bits = ^{pc_if[PC_W-1:PC_LSB+GHR_W], pc_if[PC_LSB-1:0],
                              pc_ex[PC_W-1:PC_LSB+GHR_W], pc_ex[PC_LSB-1:0]};

    assign idx_if   = pc_if[PC_LSB +: GHR_W] ^ ghr_q;
    assign idx_ex   = pc_ex[PC_LSB +: GHR_W] ^ pattern_old_ex;
    assign taken_ex = pred_bit_ex ^ miss_ex;
    assign cnt_ex   = pht_q[idx_ex];
    assign ghr_o    = ghr_q;

    // Saturating increment on taken, saturating decrement on not-taken
    always_comb begin
        cnt_new = cnt_ex;
        if (taken_ex) begin
            if (cnt_ex != 2'b11) cnt_new = cnt_ex + 2'b01;
        end else begin
            if (cnt_ex != 2'b00) cnt_new = cnt_ex - 2'b01;
        end
    end

    // Next state: GHR commits the resolved history, one PHT entry trains
    always_comb begin
        ghr_d = ghr_q;
        pht_d = pht_q;
        if (en_ex) begin
            ghr_d         = pattern_new_ex;
            pht_d[idx_ex] = cnt_new;
        end
    end

    // State registers; reset leaves every counter weakly not-taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
        end else begin
            ghr_q <= ghr_d;
            pht_q <= pht_d;
        end
    end

`ifdef GSHARE_PHT_BYPASS_EN
    // Fetch sees the counter and history being written by EX this cycle
    always_comb begin
        pred_bit_if = pht_q[idx_if][1];
        pattern_if  = ghr_q;
        if (en_ex) begin
            pattern_if = pattern_new_ex;
            if (idx_if == idx_ex) pred_bit_if = cnt_new[1];
        end
    end
`else
    // Fetch sees only committed state; same-cycle writes appear next cycle
    always_comb begin
        pred_bit_if = pht_q[idx_if][1];
        pattern_if  = ghr_q;
    end
`endif

endmodule

// File: tb/tb_gshare_pht.sv
// tb/tb_gshare_pht.sv - self-checking bench for gshare_pht against an array-based predictor model
module tb_gshare_pht;

    logic        clk;
    logic        rst;
    logic [31:0] pc_if;
    logic        pred_bit_if;
    logic [7:0]  pattern_if;
    logic        en_ex;
    logic [31:0] pc_ex;
    logic [7:0]  pattern_old_ex;
    logic        pred_bit_ex;
    logic        miss_ex;
    logic [7:0]  pattern_new_ex;
    logic [7:0]  ghr_o;

    int n_checks = 0;
    int n_fail   = 0;

    int       m_pht [256];
    bit [7:0] m_ghr;

    gshare_pht dut (
        .clk            (clk),
        .rst            (rst),
        .pc_if          (pc_if),
        .pred_bit_if    (pred_bit_if),
        .pattern_if     (pattern_if),
        .en_ex          (en_ex),
        .pc_ex          (pc_ex),
        .pattern_old_ex (pattern_old_ex),
        .pred_bit_ex    (pred_bit_ex),
        .miss_ex        (miss_ex),
        .pattern_new_ex (pattern_new_ex),
        .ghr_o          (ghr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit [7:0] hash(input bit [31:0] pc, input bit [7:0] h);
        return ((pc / 4) % 256) ^ h;
    endfunction

    function automatic int next_cnt(input int c, input bit taken);
        if (taken) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        m_ghr = 8'h00;
    endtask

    // One resolving branch over one clock edge; model follows after the edge
    task automatic resolve(input bit [31:0] pc, input bit [7:0] old, input bit pb,
                           input bit ms, input bit [7:0] nw);
        bit [7:0] i;
        en_ex = 1'b1; pc_ex = pc; pattern_old_ex = old;
        pred_bit_ex = pb; miss_ex = ms; pattern_new_ex = nw;
        @(posedge clk);
        i = hash(pc, old);
        m_pht[i] = next_cnt(m_pht[i], pb ^ ms);
        m_ghr = nw;
        #1;
        en_ex = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en_ex = 1'b0; pc_ex = '0; pattern_old_ex = '0;
        pred_bit_ex = 1'b0; miss_ex = 1'b0; pattern_new_ex = '0;
        pc_if = 32'h0000_0040;
        model_reset();
        #3;
        n_checks++;
        if (pred_bit_if !== 1'b0) begin n_fail++; $display("FAIL reset_pred got %b want 0", pred_bit_if); end
        n_checks++;
        if (pattern_if !== 8'h00) begin n_fail++; $display("FAIL reset_pattern got %h want 00", pattern_if); end
        n_checks++;
        if (ghr_o !== 8'h00) begin n_fail++; $display("FAIL reset_ghr got %h want 00", ghr_o); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_taken_training();
        resolve(32'h40, 8'h00, 1'b0, 1'b1, 8'h80);
        n_checks++;
        if (ghr_o !== 8'h80) begin n_fail++; $display("FAIL train_ghr got %h want 80", ghr_o); end
        pc_if = 32'h0000_0240;  // 0x90 ^ GHR 0x80 -> idx 0x10
        #1;
        n_checks++;
        if (pred_bit_if !== 1'b1) begin n_fail++; $display("FAIL train_pred1 got %b want 1", pred_bit_if); end
        resolve(32'h40, 8'h00, 1'b1, 1'b0, 8'h00);
        pc_if = 32'h0000_0040;
        #1;
        n_checks++;
        if (pred_bit_if !== 1'b1) begin n_fail++; $display("FAIL train_pred2 got %b want 1", pred_bit_if); end
        n_checks++;
        if (m_pht[8'h10] != 3) begin n_fail++; $display("FAIL train_model got %0d want 3", m_pht[8'h10]); end
    endtask

    task automatic test_saturation();
        bit exp_nt [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        pc_if = 32'h0000_0040;
        for (int k = 0; k < 4; k++) begin
            resolve(32'h40, 8'h00, 1'b1, 1'b0, 8'h00);
            #1;
            n_checks++;
            if (pred_bit_if !== 1'b1) begin n_fail++; $display("FAIL sat_hi_%0d got %b want 1", k, pred_bit_if); end
        end
        for (int k = 0; k < 5; k++) begin
            resolve(32'h40, 8'h00, 1'b1, 1'b1, 8'h00);
            #1;
            n_checks++;
            if (pred_bit_if !== exp_nt[k]) begin n_fail++; $display("FAIL sat_nt_%0d got %b want %b", k, pred_bit_if, exp_nt[k]); end
        end
        // From a saturated 00, one taken reaches 01 (NT) and a second reaches 10 (T)
        resolve(32'h40, 8'h00, 1'b0, 1'b1, 8'h00);
        #1;
        n_checks++;
        if (pred_bit_if !== 1'b0) begin n_fail++; $display("FAIL sat_lo_up1 got %b want 0", pred_bit_if); end
        resolve(32'h40, 8'h00, 1'b0, 1'b1, 8'h00);
        #1;
        n_checks++;
        if (pred_bit_if !== 1'b1) begin n_fail++; $display("FAIL sat_lo_up2 got %b want 1", pred_bit_if); end
    endtask

    task automatic test_ghr_hold();
        bit exp_p;
        resolve(32'h0000_0100, 8'h00, 1'b0, 1'b0, 8'hA5);
        n_checks++;
        if (ghr_o !== 8'hA5) begin n_fail++; $display("FAIL ghr_load got %h want a5", ghr_o); end
        en_ex = 1'b0; pattern_new_ex = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ghr_o !== 8'hA5) begin n_fail++; $display("FAIL ghr_hold_%0d got %h want a5", k, ghr_o); end
        end
        pc_if = 32'h0000_0294;
        #1;
        exp_p = (m_pht[hash(pc_if, m_ghr)] >= 2);
        n_checks++;
        if (pattern_if !== 8'hA5) begin n_fail++; $display("FAIL ghr_pattern got %h want a5", pattern_if); end
        n_checks++;
        if (pred_bit_if !== exp_p) begin n_fail++; $display("FAIL ghr_idx0_pred got %b want %b", pred_bit_if, exp_p); end
    endtask

    task automatic test_collision();
        bit       exp_p;
        bit [7:0] exp_pat;
        test_reset();
        pc_if = 32'h0000_0040;
        en_ex = 1'b1; pc_ex = 32'h40; pattern_old_ex = 8'h00;
        pred_bit_ex = 1'b0; miss_ex = 1'b1; pattern_new_ex = 8'h33;
        #2;
`ifdef GSHARE_PHT_BYPASS_EN
        exp_p = 1'b1; exp_pat = 8'h33;
`else
        exp_p = 1'b0; exp_pat = 8'h00;
`endif
        n_checks++;
        if (pred_bit_if !== exp_p) begin n_fail++; $display("FAIL collide_pred got %b want %b", pred_bit_if, exp_p); end
        n_checks++;
        if (pattern_if !== exp_pat) begin n_fail++; $display("FAIL collide_pattern got %h want %h", pattern_if, exp_pat); end
        @(posedge clk);
        m_pht[8'h10] = 2; m_ghr = 8'h33;
        #1;
        en_ex = 1'b0;
        pc_if = 32'h0000_0040 ^ {22'h0, 8'h33, 2'b00};
        #1;
        n_checks++;
        if (pred_bit_if !== 1'b1) begin n_fail++; $display("FAIL collide_after got %b want 1", pred_bit_if); end
    endtask

    task automatic test_random();
        bit [7:0] ie, ii;
        bit       tk, exp_p;
        bit [7:0] exp_pat;
        int       c;
        for (int n = 0; n < 200; n++) begin
            en_ex          = 1'($urandom_range(0, 1));
            pc_ex          = $urandom;
            pc_ex[9:2]     = 8'h10 + 8'($urandom_range(0, 3));
            pattern_old_ex = 8'($urandom_range(0, 3));
            pred_bit_ex    = 1'($urandom_range(0, 1));
            miss_ex        = 1'($urandom_range(0, 1));
            pattern_new_ex = 8'($urandom_range(0, 3));
            ie = hash(pc_ex, pattern_old_ex);
            tk = pred_bit_ex ^ miss_ex;
            pc_if = $urandom;
            if ($urandom_range(0, 1) == 1) pc_if[9:2] = ie ^ m_ghr;
            ii = hash(pc_if, m_ghr);
            c = m_pht[ii];
            exp_pat = m_ghr;
`ifdef GSHARE_PHT_BYPASS_EN
            if (en_ex && ii == ie) c = next_cnt(m_pht[ie], tk);
            if (en_ex) exp_pat = pattern_new_ex;
`endif
            exp_p = (c >= 2);
            #2;
            n_checks++;
            if (pred_bit_if !== exp_p) begin n_fail++; $display("FAIL rand_pred_%0d got %b want %b", n, pred_bit_if, exp_p); end
            n_checks++;
            if (pattern_if !== exp_pat) begin n_fail++; $display("FAIL rand_pattern_%0d got %h want %h", n, pattern_if, exp_pat); end
            n_checks++;
            if (ghr_o !== m_ghr) begin n_fail++; $display("FAIL rand_ghr_%0d got %h want %h", n, ghr_o, m_ghr); end
            @(posedge clk);
            if (en_ex) begin
                m_pht[ie] = next_cnt(m_pht[ie], tk);
                m_ghr = pattern_new_ex;
            end
            #1;
        end
        en_ex = 1'b0;
    endtask

    task automatic test_async_reset();
        resolve(32'h40, 8'h00, 1'b0, 1'b1, 8'hA5);
        pc_if = 32'h0000_0040 ^ {22'h0, 8'hA5, 2'b00};
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (ghr_o !== 8'h00) begin n_fail++; $display("FAIL arst_ghr got %h want 00", ghr_o); end
        n_checks++;
        if (pred_bit_if !== 1'b0) begin n_fail++; $display("FAIL arst_pred got %b want 0", pred_bit_if); end
        n_checks++;
        if (pattern_if !== 8'h00) begin n_fail++; $display("FAIL arst_pattern got %h want 00", pattern_if); end
        en_ex = 1'b1; pc_ex = 32'h40; pattern_old_ex = 8'h00;
        pred_bit_ex = 1'b1; miss_ex = 1'b0; pattern_new_ex = 8'h5A;
        @(posedge clk); #1;
        n_checks++;
        if (ghr_o !== 8'h00) begin n_fail++; $display("FAIL arst_edge_ghr got %h want 00", ghr_o); end
        en_ex = 1'b0;
        #2;
        rst = 1'b0;
        pc_if = 32'h0000_0040;
        #1;
        n_checks++;
        if (pred_bit_if !== 1'b0) begin n_fail++; $display("FAIL arst_pht got %b want 0", pred_bit_if); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_taken_training();
        test_saturation();
        test_ghr_hold();
        test_collision();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
